evt_debounce: RTL and testbench

//  Turns a raw asynchronous input (button, sensor, external strobe) into clean

---
 rtl/evt_debounce_if.sv | 25 ++
 rtl/evt_debounce.sv | 147 ++++++++++++++
 tb/tb_evt_debounce.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/evt_debounce_if.sv
// Event debouncer bundle: raw input toward the debouncer and cleaned results back.
interface evt_debounce_if;

    logic sig_in;
    logic level_out;
    logic evt_out;
    logic reject_out;

    // Driver of the raw input; consumer of the cleaned level and pulses.
    modport master (
        output sig_in,
        input  level_out,
        input  evt_out,
        input  reject_out
    );

    // The debouncer itself.
    modport slave (
        input  sig_in,
        output level_out,
        output evt_out,
        output reject_out
    );

endinterface : evt_debounce_if

// File: rtl/evt_debounce.sv
// Synchronise, debounce and edge-detect a raw asynchronous input into clean
// single-cycle event pulses, plus a pulse whenever bounce aborts a pending change.
module evt_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned EDGE_MODE       = 0
) (
    input  logic           clk_in,
    input  logic           rst_in,
    evt_debounce_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // The rising edge is reported in modes 0 and 2, the falling edge in modes 1 and 2.
    localparam logic PULSE_ON_RISE = (EDGE_MODE != 32'd1);
    localparam logic PULSE_ON_FALL = (EDGE_MODE != 32'd0);

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        CONF_HI = 2'd1,
        IDLE_HI = 2'd2,
        CONF_LO = 2'd3
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_e                 state_q;
    state_e                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   level_q;
    logic                   level_d;
    logic                   evt_q;
    logic                   evt_d;
    logic                   reject_q;
    logic                   reject_d;

    // Synchroniser chain; only its last stage is visible to the FSM.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sig_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // State, counter and registered outputs; reset overrides any pending confirmation.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= IDLE_LO;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            evt_q    <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            evt_q    <= evt_d;
            reject_q <= reject_d;
        end
    end

    // Next state: leave an idle state on a level change, leave a confirm state on
    // a reversal (abort) or once the level has held for the full debounce window.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE_LO: begin
                if (s) begin
                    state_d = CONF_HI;
                end
            end
            CONF_HI: begin
                if (!s) begin
                    state_d = IDLE_LO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HI;
                end
            end
            IDLE_HI: begin
                if (!s) begin
                    state_d = CONF_LO;
                end
            end
            CONF_LO: begin
                if (s) begin
                    state_d = IDLE_HI;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LO;
                end
            end
            default: state_d = IDLE_LO;
        endcase
    end

    // Next values of the counter and outputs. Pulses default low so each lasts one
    // cycle; the counter is zero whenever a confirm state is entered.
    always_comb begin
        cnt_d    = cnt_q;
        level_d  = level_q;
        evt_d    = 1'b0;
        reject_d = 1'b0;
        unique case (state_q)
            IDLE_LO, IDLE_HI: begin
                cnt_d = '0;
            end
            CONF_HI: begin
                if (!s) begin
                    reject_d = 1'b1;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_LAST) begin
                    level_d = 1'b1;
                    evt_d   = PULSE_ON_RISE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CONF_LO: begin
                if (s) begin
                    reject_d = 1'b1;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_LAST) begin
                    level_d = 1'b0;
                    evt_d   = PULSE_ON_FALL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign bus.level_out  = level_q;
    assign bus.evt_out    = evt_q;
    assign bus.reject_out = reject_q;

endmodule : evt_debounce

// File: tb/tb_evt_debounce.sv
// Directed bench for evt_debounce: four instances with different parameters share
// one raw input and reset; expected values are hand-derived edge numbers.
module tb_evt_debounce;

    logic clk;
    logic rst;
    logic sig;

    int n_chk;
    int n_err;

    // Rising edge, D=4 | falling edge, D=4 | both edges, D=4 | rising edge, D=16
    evt_debounce_if if_r ();
    evt_debounce_if if_f ();
    evt_debounce_if if_b ();
    evt_debounce_if if_k ();

    assign if_r.sig_in = sig;
    assign if_f.sig_in = sig;
    assign if_b.sig_in = sig;
    assign if_k.sig_in = sig;

    evt_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),  .EDGE_MODE(0)) u_r (
        .clk_in(clk), .rst_in(rst), .bus(if_r.slave));
    evt_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),  .EDGE_MODE(1)) u_f (
        .clk_in(clk), .rst_in(rst), .bus(if_f.slave));
    evt_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),  .EDGE_MODE(2)) u_b (
        .clk_in(clk), .rst_in(rst), .bus(if_b.slave));
    evt_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .EDGE_MODE(0)) u_k (
        .clk_in(clk), .rst_in(rst), .bus(if_k.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream event-counter model for the D=16 instance, plus a back-to-back pulse watch.
    logic cnt_en;
    int   n_evt_k;
    int   n_rej_k;
    logic prev_r;
    logic prev_b;
    logic consec;

    initial begin
        cnt_en  = 1'b0;
        n_evt_k = 0;
        n_rej_k = 0;
        prev_r  = 1'b0;
        prev_b  = 1'b0;
        consec  = 1'b0;
    end

    always @(negedge clk) begin
        if (cnt_en) begin
            if (if_k.evt_out === 1'b1)    n_evt_k = n_evt_k + 1;
            if (if_k.reject_out === 1'b1) n_rej_k = n_rej_k + 1;
        end
        if ((prev_r && if_r.evt_out) || (prev_b && if_b.evt_out)) consec = 1'b1;
        prev_r = if_r.evt_out;
        prev_b = if_b.evt_out;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past one active edge; outputs are stable when this returns.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        n_chk = 0;
        n_err = 0;
        rst   = 1'b1;
        sig   = 1'b0;

        // Reset state
        repeat (4) tick();
        check("rst_level", 32'(if_r.level_out), 32'd0);
        check("rst_evt",   32'(if_r.evt_out),   32'd0);
        check("rst_rej",   32'(if_r.reject_out), 32'd0);
        check("rst_level_b", 32'(if_b.level_out), 32'd0);
        rst = 1'b0;
        repeat (3) tick();

        // Clean rise: level and pulse at edge S+D = 6
        sig = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            check($sformatf("rise_lvl_k%0d", k),  32'(if_r.level_out),  32'(k >= 6));
            check($sformatf("rise_evt_k%0d", k),  32'(if_r.evt_out),    32'(k == 6));
            check($sformatf("rise_rej_k%0d", k),  32'(if_r.reject_out), 32'd0);
            check($sformatf("rise_evtb_k%0d", k), 32'(if_b.evt_out),    32'(k == 6));
            check($sformatf("rise_evtf_k%0d", k), 32'(if_f.evt_out),    32'd0);
            check($sformatf("rise_lvlf_k%0d", k), 32'(if_f.level_out),  32'(k >= 6));
        end
        repeat (11) tick();

        // Clean fall: only the falling-edge and both-edge instances pulse
        sig = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick();
            check($sformatf("fall_lvl_k%0d", k),  32'(if_r.level_out), 32'(k < 6));
            check($sformatf("fall_evt_k%0d", k),  32'(if_r.evt_out),   32'd0);
            check($sformatf("fall_evtb_k%0d", k), 32'(if_b.evt_out),   32'(k == 6));
            check($sformatf("fall_evtf_k%0d", k), 32'(if_f.evt_out),   32'(k == 6));
            check($sformatf("fall_lvlb_k%0d", k), 32'(if_b.level_out), 32'(k < 6));
        end
        repeat (5) tick();

        // Short high (3 sampled cycles): aborted, reject at edge 5
        sig = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("bnc_rej_k%0d", k), 32'(if_r.reject_out), 32'(k == 5));
            check($sformatf("bnc_lvl_k%0d", k), 32'(if_r.level_out),  32'd0);
            check($sformatf("bnc_evt_k%0d", k), 32'(if_r.evt_out),    32'd0);
            if (k == 2) sig = 1'b0;
        end
        repeat (5) tick();

        // Reset while confirming high with cnt=2 (after edge 4), then full latency again
        sig = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_level", 32'(if_r.level_out),  32'd0);
        check("mrst_evt",   32'(if_r.evt_out),    32'd0);
        check("mrst_rej",   32'(if_r.reject_out), 32'd0);
        for (int k = 0; k < 9; k++) begin
            tick();
            check($sformatf("mrst_lvl_k%0d", k), 32'(if_r.level_out), 32'(k >= 6));
            check($sformatf("mrst_evt_k%0d", k), 32'(if_r.evt_out),   32'(k == 6));
        end
        sig = 1'b0;
        repeat (15) tick();

        // Input high across reset release: treated as a rising edge
        rst = 1'b1;
        sig = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("rel_evt_k%0d", k), 32'(if_r.evt_out),   32'(k == 6));
            check($sformatf("rel_lvl_k%0d", k), 32'(if_r.level_out), 32'(k >= 6));
        end
        n = 0;
        repeat (20) begin
            tick();
            if (if_r.evt_out === 1'b1) n = n + 1;
        end
        check("rel_extra_evt", 32'(n), 32'd0);

        // 10 presses, each preceded by 5 short glitches, into the D=16 instance
        sig = 1'b0;
        repeat (40) tick();
        n_evt_k = 0;
        n_rej_k = 0;
        cnt_en  = 1'b1;
        for (int p = 0; p < 10; p++) begin
            for (int g = 0; g < 5; g++) begin
                sig = 1'b1;
                repeat (2) tick();
                sig = 1'b0;
                repeat (4) tick();
            end
            sig = 1'b1;
            repeat (30) tick();
            sig = 1'b0;
            repeat (30) tick();
        end
        cnt_en = 1'b0;
        check("chain_count",   32'(n_evt_k), 32'd10);
        check("chain_rejects", 32'(n_rej_k), 32'd50);
        check("chain_level",   32'(if_k.level_out), 32'd0);
        check("no_consec_evt", 32'(consec), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_evt_debounce
